pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage core. Turns stage stall requests and the EX
//   branch-mispredict pulse into one StallBus code per pipeline register (pc, if_id, id_ex,
//   ex_mem, mem_wb) plus a gated flush strobe. Tracks multi-cycle memory waits, defers flushes
//   that arrive during a memory stall, and discards stale fetches after a redirect.
// PARAMETERS
//   STALL_W       2   width of StallBus code
//   FLUSH_CYCLES  1   cycles if_id is forced to Bubb after a flush (1..7)
//   CNT_W         32  width of perf counters (only with STALL_PERF_EN)
// PORTS
//   clk             in   1        core clock; all state on posedge
//   rst_n           in   1        asynchronous, active-low reset
//   if_stall_req    in   1        IF waiting on instruction memory
//   id_stall_req    in   1        ID load-use hazard
//   mem_stall_req   in   1        MEM data access not complete
//   branch_error_i  in   1        EX mispredict, 1-cycle pulse
//   stall_pc        out  STALL_W  code for PC register
//   stall_if_id     out  STALL_W  code for IF/ID
//   stall_id_ex     out  STALL_W  code for ID/EX
//   stall_ex_mem    out  STALL_W  code for EX/MEM
//   stall_mem_wb    out  STALL_W  code for MEM/WB
//   branch_flush_o  out  1        flush strobe to if_id/id_ex branch_error inputs
//   stall_cycles    out  CNT_W    cycles with any non-Pass code (perf)
//   flush_count     out  CNT_W    flushes issued (perf)
// BEHAVIOUR
//   - Codes: Pass=2'b00 (load), Hold=2'b01 (keep), Bubb=2'b10 (clear to 0). 2'b11 never driven.
//   - Outputs combinational from state + current requests (0-cycle latency; needed same cycle).
//   - FSM: RUN, MEM_WAIT, FLUSH. Reset -> RUN, flush_pend=0, flush_cnt=0, counters=0.
//   - Priority in any state: mem_stall > flush > id_stall > if_stall > none.
//   - mem_stall_req=1: pc/if_id/id_ex/ex_mem=Hold, mem_wb=Bubb, branch_flush_o=0; state->MEM_WAIT.
//     branch_error_i seen here sets flush_pend (sticky; EX/MEM is held so pulse is not lost).
//   - Flush (branch_error_i & ~mem_stall_req, or flush_pend on first cycle mem_stall_req=0):
//     branch_flush_o=1, pc=Pass (redirect), if_id=Bubb, id_ex=Bubb, ex_mem/mem_wb=Pass;
//     clear flush_pend, load flush_cnt=FLUSH_CYCLES, state->FLUSH. id/if stall ignored that cycle.
//   - FLUSH: if_id=Bubb while flush_cnt!=0, decrement each cycle; pc Hold only if if_stall_req.
//     id_stall_req ignored (ID holds a bubble). At 0 -> RUN. New flush reloads count.
//   - id_stall_req: pc=Hold, if_id=Hold, id_ex=Bubb, rest Pass.
//   - if_stall_req only: pc=Hold, if_id=Bubb, rest Pass.
//   - No request: all Pass. MEM_WAIT -> RUN when mem_stall_req drops (FLUSH if flush_pend).
//   - Reset mid-stall/mid-flush: async return to RUN, pending flush dropped; all codes Pass
//     while rst_n=0 (pipeline regs self-clear on reset).
// CONFIGURATION
//   STALL_PERF_EN defined: stall_cycles +1 per cycle with any code != Pass; flush_count +1 per
//   branch_flush_o; both saturate at all-ones, cleared by rst_n.
//   Not defined: no counter flops; stall_cycles/flush_count tied to 0.
// STRUCTURE
//   `Pass/`Hold/`Bubb, `StallBus and state encodings live in shared config.v.
//   One sub-module: stall_perf_cnt (saturating counter pair), instantiated only under the macro.
// TESTING
//   1 mem_stall_req high 3 cycles -> pc..ex_mem=01, mem_wb=10 x3; cycle 4 all 00, state RUN.
//   2 branch_error_i with no stall -> same cycle branch_flush_o=1, if_id=id_ex=10, pc=00;
//     next FLUSH_CYCLES=1 cycle if_id=10, then all 00.
//   3 branch_error_i during mem stall (cycle 2 of 4) -> branch_flush_o=0 while stalled,
//     =1 exactly once on first cycle mem_stall_req=0.
//   4 id_stall_req & if_stall_req together -> pc=01, if_id=01, id_ex=10, ex_mem=mem_wb=00.
//   5 rst_n low in MEM_WAIT with flush_pend=1 -> after release no flush; all 00 with no reqs.
//   6 STALL_PERF_EN: 5 stall cycles + 2 flushes -> stall_cycles counts every non-Pass cycle
//     incl. flush/FLUSH-state cycles, flush_count=2; without macro both read 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: StallBus codes,
// sequencer states and the width of the post-flush bubble counter.
package pipeline_stall_ctrl_pkg;

    localparam logic [1:0] CODE_PASS = 2'b00;
    localparam logic [1:0] CODE_HOLD = 2'b01;
    localparam logic [1:0] CODE_BUBB = 2'b10;

    // Wide enough for the largest supported FLUSH_CYCLES value (7).
    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_perf_cnt.sv
// Saturating stall-cycle / flush counter pair for the stall sequencer.
// Only instantiated when STALL_PERF_EN is defined.
module pipeline_stall_ctrl_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_inc_i,
    input  logic             flush_inc_i,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc_i && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (flush_inc_i && (flush_q != '1)) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: one StallBus code per pipeline register.
// Optional perf counters are built only when STALL_PERF_EN is defined.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int STALL_W      = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_stall_req,
    input  logic               id_stall_req,
    input  logic               mem_stall_req,
    input  logic               branch_error_i,
    output logic [STALL_W-1:0] stall_pc,
    output logic [STALL_W-1:0] stall_if_id,
    output logic [STALL_W-1:0] stall_id_ex,
    output logic [STALL_W-1:0] stall_ex_mem,
    output logic [STALL_W-1:0] stall_mem_wb,
    output logic               branch_flush_o,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_count
);

    localparam logic [STALL_W-1:0] PASS = STALL_W'(CODE_PASS);
    localparam logic [STALL_W-1:0] HOLD = STALL_W'(CODE_HOLD);
    localparam logic [STALL_W-1:0] BUBB = STALL_W'(CODE_BUBB);

    state_e                   state_q, state_d;
    logic                     flush_pend_q, flush_pend_d;
    logic [FLUSH_CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                     do_flush;

    // A pending flush only fires once the memory stall has released EX/MEM.
    assign do_flush = ~mem_stall_req & (branch_error_i | flush_pend_q);

    always_comb begin
        stall_pc       = PASS;
        stall_if_id    = PASS;
        stall_id_ex    = PASS;
        stall_ex_mem   = PASS;
        stall_mem_wb   = PASS;
        branch_flush_o = 1'b0;
        state_d        = state_q;
        flush_pend_d   = flush_pend_q;
        flush_cnt_d    = flush_cnt_q;

        if (!rst_n) begin
            state_d = ST_RUN;
        end else if (mem_stall_req) begin
            stall_pc     = HOLD;
            stall_if_id  = HOLD;
            stall_id_ex  = HOLD;
            stall_ex_mem = HOLD;
            stall_mem_wb = BUBB;
            state_d      = ST_MEM_WAIT;
            if (branch_error_i) begin
                flush_pend_d = 1'b1;
            end
        end else if (do_flush) begin
            branch_flush_o = 1'b1;
            stall_if_id    = BUBB;
            stall_id_ex    = BUBB;
            flush_pend_d   = 1'b0;
            flush_cnt_d    = FLUSH_CNT_W'(FLUSH_CYCLES);
            state_d        = ST_FLUSH;
        end else if (state_q == ST_FLUSH) begin
            // Redirect window: discard stale fetches; ID already holds a bubble.
            stall_pc = if_stall_req ? HOLD : PASS;
            state_d  = ST_RUN;
            if (flush_cnt_q != '0) begin
                stall_if_id = BUBB;
                flush_cnt_d = flush_cnt_q - 1'b1;
                if (flush_cnt_q != FLUSH_CNT_W'(1)) begin
                    state_d = ST_FLUSH;
                end
            end
        end else if (id_stall_req) begin
            stall_pc    = HOLD;
            stall_if_id = HOLD;
            stall_id_ex = BUBB;
            state_d     = ST_RUN;
        end else if (if_stall_req) begin
            stall_pc    = HOLD;
            stall_if_id = BUBB;
            state_d     = ST_RUN;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            flush_pend_q <= 1'b0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

`ifdef STALL_PERF_EN
    logic any_stall;

    assign any_stall = (stall_pc     != PASS) | (stall_if_id  != PASS) |
                       (stall_id_ex  != PASS) | (stall_ex_mem != PASS) |
                       (stall_mem_wb != PASS);

    pipeline_stall_ctrl_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_inc_i    (any_stall),
        .flush_inc_i    (branch_flush_o),
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus random
// request streams, compared every cycle against a behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int STALL_W      = 2;
    localparam int FLUSH_CYCLES = 1;
    localparam int CNT_W        = 32;

    localparam logic [1:0] P = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] B = 2'b10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ifStall, idStall, memStall, branchError;
    logic [STALL_W-1:0] stallPc, stallIfId, stallIdEx, stallExMem, stallMemWb;
    logic               branchFlush;
    logic [CNT_W-1:0]   stallCycles, flushCount;

    int checkCount = 0;
    int errorCount = 0;

    // Model: a pending-flush flag, bubbles still owed to IF/ID, and perf totals.
    bit modelPend;
    int modelBubbles;
    int modelStalls;
    int modelFlushes;

    pipeline_stall_ctrl #(
        .STALL_W      (STALL_W),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_stall_req   (ifStall),
        .id_stall_req   (idStall),
        .mem_stall_req  (memStall),
        .branch_error_i (branchError),
        .stall_pc       (stallPc),
        .stall_if_id    (stallIfId),
        .stall_id_ex    (stallIdEx),
        .stall_ex_mem   (stallExMem),
        .stall_mem_wb   (stallMemWb),
        .branch_flush_o (branchFlush),
        .stall_cycles   (stallCycles),
        .flush_count    (flushCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkCounters();
`ifdef STALL_PERF_EN
        checkOutput("stall_cycles", stallCycles, modelStalls);
        checkOutput("flush_count", flushCount, modelFlushes);
`else
        checkOutput("stall_cycles", stallCycles, 32'd0);
        checkOutput("flush_count", flushCount, 32'd0);
`endif
    endtask

    // Drive one cycle of requests, predict the codes from the rules, then compare.
    task automatic applyStimulus(input bit mem, input bit br, input bit idr, input bit ifr);
        logic [1:0] ePc, eIfId, eIdEx, eExMem, eMemWb;
        bit         eFlush;
        @(negedge clk);
        memStall    = mem;
        branchError = br;
        idStall     = idr;
        ifStall     = ifr;
        #2;
        {ePc, eIfId, eIdEx, eExMem, eMemWb} = {P, P, P, P, P};
        eFlush = 1'b0;
        if (mem) begin
            {ePc, eIfId, eIdEx, eExMem, eMemWb} = {H, H, H, H, B};
            if (br) modelPend = 1'b1;
            modelBubbles = 0;
        end else if (br || modelPend) begin
            eFlush = 1'b1;
            eIfId  = B;
            eIdEx  = B;
            modelPend    = 1'b0;
            modelBubbles = FLUSH_CYCLES;
        end else if (modelBubbles > 0) begin
            ePc   = ifr ? H : P;
            eIfId = B;
            modelBubbles--;
        end else if (idr) begin
            {ePc, eIfId, eIdEx} = {H, H, B};
        end else if (ifr) begin
            {ePc, eIfId} = {H, B};
        end
        checkOutput("codes", {21'd0, stallPc, stallIfId, stallIdEx, stallExMem, stallMemWb, branchFlush},
                    {21'd0, ePc, eIfId, eIdEx, eExMem, eMemWb, eFlush});
        checkCounters();
        if ({ePc, eIfId, eIdEx, eExMem, eMemWb} != 10'd0) modelStalls++;
        if (eFlush) modelFlushes++;
    endtask

    // Pull reset low for a full clock edge; everything reads Pass and the model forgets.
    task automatic applyReset();
        @(negedge clk);
        rst_n       = 1'b0;
        memStall    = 1'($urandom_range(0, 1));
        branchError = 1'($urandom_range(0, 1));
        idStall     = 1'($urandom_range(0, 1));
        ifStall     = 1'($urandom_range(0, 1));
        #2;
        modelPend    = 1'b0;
        modelBubbles = 0;
        modelStalls  = 0;
        modelFlushes = 0;
        checkOutput("reset_codes", {21'd0, stallPc, stallIfId, stallIdEx, stallExMem, stallMemWb, branchFlush}, 32'd0);
        checkCounters();
        @(posedge clk);
        #1;
        checkOutput("reset_hold_codes", {21'd0, stallPc, stallIfId, stallIdEx, stallExMem, stallMemWb, branchFlush}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        memStall    = 1'b0;
        branchError = 1'b0;
        idStall     = 1'b0;
        ifStall     = 1'b0;
        modelPend    = 1'b0;
        modelBubbles = 0;
        modelStalls  = 0;
        modelFlushes = 0;
        repeat (2) @(posedge clk);
        applyReset();

        $display("[TB] mem stall for three cycles");
        repeat (3) applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] mispredict with no stall");
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] mispredict deferred by mem stall");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] id and if stall together");
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1);

        $display("[TB] reset with a pending flush");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyReset();
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] random request streams");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                applyReset();
            end else begin
                applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            end
        end
        applyStimulus(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
